qam_cfg_ctrl: RTL and testbench
===============================

# qam_cfg_ctrl

Runtime configuration sequencer for the QAM modulator datapath. It accepts new modulation settings from a host over a req/ack handshake and applies them only at a symbol boundary: a clean datapath flush, then a baud-dependent settling window before the output is declared valid. It sits between the host/register interface and the modulator top-level. It drives that block's `mod_type`, `baud_rate`, `filter_enable`, `carrier_freq_set` and active-low `rst_n` inputs.

## Interface
- `FLUSH_CYCLES`, 16: cycles `dp_rst_n` is held low during a flush (≥1).
- `SETTLE_BASE`, 4608: settle cycles at 19200 Bd (8 symbols at 11.0592 MHz); scaled by `1 << (3 - baud_rate)`. Must be ≤ 8191.
- `BOUND_TIMEOUT`, 8192: maximum cycles to wait for `sym_tick` before forcing the apply.

- `clk` in 1: single clock, 11.0592 MHz; every port is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `sym_tick` in 1: one-cycle pulse per symbol boundary, taken from the datapath symbol clock edge.
- `cfg_req` in 1: host request, level-sensitive.
- `cfg_mod_type` in 1: requested modulation, QPSK(0) / 16QAM(1).
- `cfg_baud_rate` in 2: requested baud rate, 2400(00) / 4800(01) / 9600(10) / 19200(11).
- `cfg_filter_enable` in 1: requested shaping-filter enable.
- `cfg_carrier_freq` in 16: requested carrier frequency.
- `cfg_ack` out 1: one-cycle pulse when the request is captured.
- `cfg_done` out 1: one-cycle pulse when the state returns to RUN.
- `cfg_busy` out 1: high in every state except RUN.
- `cfg_timeout` out 1: sticky flag, set when an apply was forced by timeout; cleared only by `rst`.
- `mod_type` out 1: applied modulation.
- `baud_rate` out 2: applied baud rate.
- `filter_enable` out 1: applied filter enable.
- `carrier_freq_set` out 16: applied carrier frequency.
- `dp_rst_n` out 1: active-low reset to the datapath.
- `out_valid` out 1: modulator output is trustworthy.

## Operation
- **States:** INIT, RUN, WAIT_BND, FLUSH, APPLY, SETTLE.
- **INIT** (entered on `rst`):
  - Config outputs take defaults: `mod_type`=0, `baud_rate`=2'b00, `filter_enable`=0, `carrier_freq_set`=0.
  - `dp_rst_n`=0 for `FLUSH_CYCLES`, then go to SETTLE.
- **RUN:**
  - `cfg_busy`=0 and `out_valid`=1.
  - When `cfg_req`=1, capture all `cfg_*` into shadow registers, pulse `cfg_ack`, and go to WAIT_BND.
  - `cfg_req` is ignored in every other state. The host must keep it high until `cfg_ack`.
- **WAIT_BND:**
  - Leave on `sym_tick`=1, or when the wait counter reaches `BOUND_TIMEOUT`-1. The timeout path also sets `cfg_timeout`.
  - Next state by change class:
    - Only `carrier_freq` differs from the applied value: go to APPLY, no flush.
    - Any of `mod_type`, `baud_rate` or `filter_enable` differs: go to FLUSH.
    - Shadow equals the applied config: go straight to RUN, pulse `cfg_done`, and leave `out_valid` high.
- **FLUSH:**
  - `dp_rst_n`=0 and `out_valid`=0 for `FLUSH_CYCLES`, then go to APPLY.
- **APPLY:** one cycle.
  - Copy shadow to the config outputs and release `dp_rst_n`.
  - After a carrier-only change, go to RUN with `cfg_done` and `out_valid` never dropped.
  - After a flush, go to SETTLE.
- **SETTLE:**
  - `out_valid`=0.
  - Count `SETTLE_BASE << (3 - baud_rate)` cycles using the applied `baud_rate`, then go to RUN and pulse `cfg_done`.
- **Counter:** one shared 16-bit counter, cleared on every state entry.
- **Outputs:** config outputs change only in APPLY or on `rst`, so they are glitch-free to the datapath.

## Timing
- **Reset values:**
  - `cfg_ack`=0, `cfg_done`=0, `cfg_busy`=1, `cfg_timeout`=0, `out_valid`=0, `dp_rst_n`=0.
  - Config outputs as listed under INIT.
- **Boot:** from `rst` deassertion, RUN is reached after `FLUSH_CYCLES` + 4608·8 cycles. `dp_rst_n` rises after `FLUSH_CYCLES`.
- **Request capture:**
  - `cfg_req` is sampled at edge N while in RUN.
  - `cfg_ack`=1 and `cfg_busy`=1 are registered outputs in cycle N+1.
- **`sym_tick` in WAIT_BND:** a tick sampled in the first WAIT_BND cycle counts. A tick in RUN is ignored.
- **Simultaneous tick and timeout:** the tick wins, and `cfg_timeout` is not set.
- **Flushed change:** APPLY lands exactly `FLUSH_CYCLES` cycles after the WAIT_BND exit.
- **Config outputs and `dp_rst_n`:** both update on the same edge, in the APPLY cycle.
- **`cfg_done`:** asserted in the same cycle as the first `out_valid`=1, except on the no-change path.
- **`rst` mid-sequence:** any state returns to INIT.
  - The shadow is discarded.
  - `cfg_done` is never pulsed for the aborted request.
  - `cfg_timeout` is cleared.

## Test plan
Run with `FLUSH_CYCLES`=4, `SETTLE_BASE`=8, `BOUND_TIMEOUT`=32.
- **Boot:** `rst` held 3 cycles, then released.
  - `dp_rst_n` stays 0 for 4 cycles.
  - `out_valid` rises 4+64 cycles after release, together with a `cfg_done` pulse.
- **Full change:** `baud_rate` 00→11, `mod_type` 0→1; `sym_tick` arrives 5 cycles after `cfg_ack`.
  - Sequence is FLUSH (4 cycles), APPLY, SETTLE (8 cycles).
  - Outputs read 1/11.
  - `out_valid` stays low for 4+1+8 cycles.
- **Carrier-only change:** `carrier_freq` 0→3380.
  - `dp_rst_n` and `out_valid` stay high throughout.
  - `carrier_freq_set`=3380 one cycle after the tick.
- **No `sym_tick`:** forced apply 32 cycles after WAIT_BND entry; `cfg_timeout`=1 and stays set until `rst`.
- **Busy and abort:**
  - A `cfg_req` pulse during SETTLE gets no `cfg_ack`.
  - `rst` asserted during FLUSH gives INIT with default outputs and no `cfg_done`.

Source files
------------

// File: rtl/qam_cfg_ctrl_if.sv
// Host-side configuration handshake bundle for qam_cfg_ctrl.
// master: host (drives request and settings); slave: controller (drives status).
interface qam_cfg_ctrl_if;
   logic        cfg_req;
   logic        cfg_mod_type;
   logic [1:0]  cfg_baud_rate;
   logic        cfg_filter_enable;
   logic [15:0] cfg_carrier_freq;
   logic        cfg_ack;
   logic        cfg_done;
   logic        cfg_busy;
   logic        cfg_timeout;

   modport master (
      output cfg_req, cfg_mod_type, cfg_baud_rate,
             cfg_filter_enable, cfg_carrier_freq,
      input  cfg_ack, cfg_done, cfg_busy, cfg_timeout
   );

   modport slave (
      input  cfg_req, cfg_mod_type, cfg_baud_rate,
             cfg_filter_enable, cfg_carrier_freq,
      output cfg_ack, cfg_done, cfg_busy, cfg_timeout
   );
endinterface

// File: rtl/qam_cfg_ctrl.sv
// QAM modulator runtime config sequencer: applies host settings at a symbol
// boundary with optional datapath flush and baud-scaled settling window.
// Ports: clk, rst (sync, active-high), sym_tick, host (cfg handshake slave),
// applied config (mod_type, baud_rate, filter_enable, carrier_freq_set),
// dp_rst_n (datapath reset, active-low), out_valid.
module qam_cfg_ctrl #(
   parameter int FLUSH_CYCLES  = 16,
   parameter int SETTLE_BASE   = 4608,
   parameter int BOUND_TIMEOUT = 8192
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sym_tick,
   qam_cfg_ctrl_if.slave host,
   output logic          mod_type,
   output logic [1:0]    baud_rate,
   output logic          filter_enable,
   output logic [15:0]   carrier_freq_set,
   output logic          dp_rst_n,
   output logic          out_valid
);

   typedef enum logic [2:0] {
      INIT, RUN, WAIT_BND, FLUSH, APPLY, SETTLE
   } state_t;

   localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
   localparam logic [15:0] BOUND_LAST = 16'(BOUND_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q;
   logic        sh_mod;
   logic [1:0]  sh_baud;
   logic        sh_filt;
   logic [15:0] sh_freq;
   logic        flushed_q;
   logic        ack_q, done_q, timeout_q;
   logic [15:0] settle_last;
   logic        flush_diff, freq_diff;
   logic        tmo_hit, bnd_hit;

   // Settle length uses the applied baud rate, 8 symbols at any rate.
   assign settle_last = (16'(SETTLE_BASE) << (2'd3 - baud_rate)) - 16'd1;

   assign flush_diff = (sh_mod != mod_type) || (sh_baud != baud_rate)
                    || (sh_filt != filter_enable);
   assign freq_diff  = sh_freq != carrier_freq_set;
   assign tmo_hit    = cnt_q == BOUND_LAST;
   assign bnd_hit    = sym_tick || tmo_hit;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT:     if (cnt_q == FLUSH_LAST) state_d = SETTLE;
         RUN:      if (host.cfg_req) state_d = WAIT_BND;
         WAIT_BND: if (bnd_hit) begin
            if (flush_diff)     state_d = FLUSH;
            else if (freq_diff) state_d = APPLY;
            else                state_d = RUN;
         end
         FLUSH:    if (cnt_q == FLUSH_LAST) state_d = APPLY;
         APPLY:    state_d = flushed_q ? SETTLE : RUN;
         SETTLE:   if (cnt_q == settle_last) state_d = RUN;
         default:  state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= INIT;
         cnt_q            <= '0;
         sh_mod           <= 1'b0;
         sh_baud          <= 2'b00;
         sh_filt          <= 1'b0;
         sh_freq          <= '0;
         flushed_q        <= 1'b0;
         ack_q            <= 1'b0;
         done_q           <= 1'b0;
         timeout_q        <= 1'b0;
         mod_type         <= 1'b0;
         baud_rate        <= 2'b00;
         filter_enable    <= 1'b0;
         carrier_freq_set <= '0;
         dp_rst_n         <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= (state_d != state_q) ? '0 : cnt_q + 16'd1;
         ack_q    <= (state_q == RUN) && host.cfg_req;
         done_q   <= (state_d == RUN) && (state_q != RUN);
         dp_rst_n <= !((state_d == INIT) || (state_d == FLUSH));
         if ((state_q == RUN) && host.cfg_req) begin
            sh_mod  <= host.cfg_mod_type;
            sh_baud <= host.cfg_baud_rate;
            sh_filt <= host.cfg_filter_enable;
            sh_freq <= host.cfg_carrier_freq;
         end
         // A tick on the last wait cycle wins over the timeout.
         if ((state_q == WAIT_BND) && tmo_hit && !sym_tick)
            timeout_q <= 1'b1;
         if (state_d == FLUSH)
            flushed_q <= 1'b1;
         else if (state_d == WAIT_BND)
            flushed_q <= 1'b0;
         // Loaded on the edge into APPLY, together with dp_rst_n release.
         if (state_d == APPLY) begin
            mod_type         <= sh_mod;
            baud_rate        <= sh_baud;
            filter_enable    <= sh_filt;
            carrier_freq_set <= sh_freq;
         end
      end
   end

   assign out_valid = (state_q == RUN) || (state_q == WAIT_BND)
                   || ((state_q == APPLY) && !flushed_q);

   assign host.cfg_ack     = ack_q;
   assign host.cfg_done    = done_q;
   assign host.cfg_busy    = state_q != RUN;
   assign host.cfg_timeout = timeout_q;

endmodule

// File: tb/tb_qam_cfg_ctrl.sv
// Randomized self-checking bench for qam_cfg_ctrl.
// Expected timings come from per-request arithmetic on the change class.
module tb_qam_cfg_ctrl;
   localparam int F = 4;
   localparam int S = 8;
   localparam int B = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sym_tick = 1'b0;
   logic        mod_type;
   logic [1:0]  baud_rate;
   logic        filter_enable;
   logic [15:0] carrier_freq_set;
   logic        dp_rst_n;
   logic        out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: applied config {mod, baud[1:0], filt, freq[15:0]} and sticky flag.
   logic [19:0] m_cfg;
   logic        m_tmo;

   qam_cfg_ctrl_if host ();

   qam_cfg_ctrl #(
      .FLUSH_CYCLES (F),
      .SETTLE_BASE  (S),
      .BOUND_TIMEOUT(B)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sym_tick        (sym_tick),
      .host            (host),
      .mod_type        (mod_type),
      .baud_rate       (baud_rate),
      .filter_enable   (filter_enable),
      .carrier_freq_set(carrier_freq_set),
      .dp_rst_n        (dp_rst_n),
      .out_valid       (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] cur_cfg();
      return {mod_type, baud_rate, filter_enable, carrier_freq_set};
   endfunction

   // Reset for 3 cycles, then measure the boot sequence.
   task automatic boot(input bit poke_req);
      int k, dp_low, dones, acks, up_at;
      rst = 1'b1;
      host.cfg_req = 1'b0;
      sym_tick = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(host.cfg_ack), 0);
      check("rst_done", 32'(host.cfg_done), 0);
      check("rst_busy", 32'(host.cfg_busy), 1);
      check("rst_tmo", 32'(host.cfg_timeout), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_dp", 32'(dp_rst_n), 0);
      check("rst_cfg", 32'(cur_cfg()), 0);
      rst = 1'b0;
      k = 0; dp_low = 0; dones = 0; acks = 0; up_at = -1;
      while (k < 300) begin
         if (!dp_rst_n) dp_low++;
         if (host.cfg_done) dones++;
         if (host.cfg_ack) acks++;
         if (out_valid) begin
            up_at = k;
            break;
         end
         host.cfg_req = poke_req && (k == 30);
         @(negedge clk);
         k++;
      end
      host.cfg_req = 1'b0;
      check("boot_dp_low", 32'(dp_low), F);
      check("boot_valid_at", 32'(up_at), F + S * 8);
      check("boot_done_with_valid", 32'(host.cfg_done), 1);
      check("boot_done_count", 32'(dones), 1);
      check("boot_no_ack", 32'(acks), 0);
      @(negedge clk);
      check("boot_done_pulse", 32'(host.cfg_done), 0);
      check("boot_idle", 32'(host.cfg_busy), 0);
      check("boot_ack_late", 32'(host.cfg_ack), 0);
      m_cfg = '0;
      m_tmo = 1'b0;
   endtask

   // Issue a request, hold it until ack, then ack-relative tick at cycle d.
   task automatic issue(input logic [19:0] nc, output int lat);
      host.cfg_req           = 1'b1;
      host.cfg_mod_type      = nc[19];
      host.cfg_baud_rate     = nc[18:17];
      host.cfg_filter_enable = nc[16];
      host.cfg_carrier_freq  = nc[15:0];
      @(negedge clk);
      lat = 1;
      while (!host.cfg_ack && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      host.cfg_req = 1'b0;
      // Scramble inputs; the captured shadow must not follow them.
      host.cfg_mod_type      = 1'($urandom);
      host.cfg_baud_rate     = 2'($urandom);
      host.cfg_filter_enable = 1'($urandom);
      host.cfg_carrier_freq  = 16'($urandom);
   endtask

   task automatic txn(input logic [19:0] nc, input int d);
      int k, lat, cls, e, l, lw, dl, chg_at, done_at;
      int x_chg, x_done, x_lw, x_dl;
      cls = (nc[19:16] != m_cfg[19:16]) ? 2 :
            (nc[15:0] != m_cfg[15:0]) ? 1 : 0;
      e = (d < B) ? d : B - 1;
      l = S << (3 - int'(nc[18:17]));
      x_chg  = (cls == 2) ? e + F + 1 : (cls == 1) ? e + 1 : 0;
      x_done = (cls == 2) ? e + F + 2 + l : (cls == 1) ? e + 2 : e + 1;
      x_lw   = (cls == 2) ? F + 1 + l : 0;
      x_dl   = (cls == 2) ? F : 0;
      if (d >= B) m_tmo = 1'b1;
      check("pre_busy", 32'(host.cfg_busy), 0);
      check("pre_valid", 32'(out_valid), 1);
      issue(nc, lat);
      check("ack_latency", 32'(lat), 1);
      check("ack_busy", 32'(host.cfg_busy), 1);
      k = 0; lw = 0; dl = 0; chg_at = -1; done_at = -1;
      while (k < 400) begin
         if (!out_valid) lw++;
         if (!dp_rst_n) dl++;
         if (chg_at < 0 && cur_cfg() == nc) chg_at = k;
         if (host.cfg_done) begin
            done_at = k;
            break;
         end
         sym_tick = (k == d);
         @(negedge clk);
         k++;
      end
      sym_tick = 1'b0;
      check("apply_at", 32'(chg_at), 32'(x_chg));
      check("done_at", 32'(done_at), 32'(x_done));
      check("valid_low", 32'(lw), 32'(x_lw));
      check("dp_low", 32'(dl), 32'(x_dl));
      check("cfg_out", 32'(cur_cfg()), 32'(nc));
      check("timeout", 32'(host.cfg_timeout), 32'(m_tmo));
      m_cfg = nc;
      @(negedge clk);
      check("done_pulse", 32'(host.cfg_done), 0);
   endtask

   task automatic idle();
      repeat ($urandom_range(0, 3)) begin
         sym_tick = 1'($urandom);
         @(negedge clk);
      end
      sym_tick = 1'b0;
   endtask

   task automatic rand_txn();
      logic [19:0] nc;
      int cls;
      cls = $urandom_range(0, 2);
      nc = m_cfg;
      if (cls == 1)
         nc[15:0] = m_cfg[15:0] ^ 16'($urandom_range(1, 65535));
      if (cls == 2) begin
         nc = 20'($urandom);
         if (nc[19:16] == m_cfg[19:16]) nc[16] = ~nc[16];
      end
      idle();
      txn(nc, $urandom_range(0, 40));
   endtask

   task automatic abort_in_flush();
      int lat;
      issue({~m_cfg[19], m_cfg[18:0]}, lat);
      check("abort_ack", 32'(lat), 1);
      sym_tick = 1'b1;
      @(negedge clk);
      sym_tick = 1'b0;
      @(negedge clk);
      check("abort_in_flush", 32'(dp_rst_n), 0);
      check("abort_valid", 32'(out_valid), 0);
      boot(1'b1);
   endtask

   initial begin
      host.cfg_req           = 1'b0;
      host.cfg_mod_type      = 1'b0;
      host.cfg_baud_rate     = 2'b00;
      host.cfg_filter_enable = 1'b0;
      host.cfg_carrier_freq  = '0;
      m_cfg = '0;
      m_tmo = 1'b0;
      boot(1'b0);
      txn({1'b1, 2'b11, 1'b0, 16'd0}, 5);
      txn({1'b1, 2'b11, 1'b0, 16'd3380}, 3);
      txn({1'b1, 2'b11, 1'b0, 16'd3380}, 0);
      txn({1'b1, 2'b11, 1'b0, 16'd99}, B - 1);
      txn({1'b0, 2'b01, 1'b1, 16'd99}, B - 1);
      txn({1'b0, 2'b01, 1'b1, 16'd500}, 50);
      txn({1'b0, 2'b01, 1'b1, 16'd500}, 2);
      for (int i = 0; i < 25; i++) rand_txn();
      abort_in_flush();
      for (int i = 0; i < 8; i++) rand_txn();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule
